// File: rtl/mem_line_reader.sv
// mem_line_reader
//   Fetches one 29-bit word from a serial drum memory line. A request names
//   a line (M0-M3, M19 long lines of 108 words; M20, M23 short lines of 4
//   words) and a word address. The reader waits for that word to come round
//   under the heads and shifts it in LSB first. It then holds the result
//   until the consumer takes it.
//
// Ports
//   CLOCK                    system clock, rising edge
//   rst                      synchronous active-high reset
//   BIT_CE                   one-cycle strobe per drum bit time
//   T0                       bit time 0 of every drum word (qualified by BIT_CE)
//   WT[6:0]                  current drum word time, valid with T0
//   M0..M3, M19, M20, M23    serial line bitstreams, LSB first
//   REQ_VALID / REQ_READY    request handshake
//   REQ_LINE[2:0]            0-3 = M0-M3, 4 = M19, 5 = M20, 6 = M23, 7 illegal
//   REQ_WORD[6:0]            word address
//   RSP_VALID / RSP_READY    response handshake
//   RSP_DATA[28:0]           captured word (zero on error)
//   RSP_ERR                  request rejected or framing error
module mem_line_reader (
  input  logic        CLOCK,
  input  logic        rst,
  input  logic        BIT_CE,
  input  logic        T0,
  input  logic [6:0]  WT,
  input  logic        M0,
  input  logic        M1,
  input  logic        M2,
  input  logic        M3,
  input  logic        M19,
  input  logic        M20,
  input  logic        M23,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_LINE,
  input  logic [6:0]  REQ_WORD,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [28:0] RSP_DATA,
  output logic        RSP_ERR
);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, HOLD} state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_line,  w_line_next;
  logic [6:0]  r_word,  w_word_next;
  logic [28:0] r_data,  w_data_next;
  logic        r_err,   w_err_next;
  logic [4:0]  r_cnt,   w_cnt_next;

  logic w_line_bit;
  logic w_req_illegal;
  logic w_is_short;
  logic w_word_match;

  // The mux follows the latched line code so that a consumer changing
  // REQ_LINE mid-capture cannot corrupt the word being shifted in.
  always_comb begin
    w_line_bit = 1'b0;
    case (r_line)
      3'd0:    w_line_bit = M0;
      3'd1:    w_line_bit = M1;
      3'd2:    w_line_bit = M2;
      3'd3:    w_line_bit = M3;
      3'd4:    w_line_bit = M19;
      3'd5:    w_line_bit = M20;
      3'd6:    w_line_bit = M23;
      default: w_line_bit = 1'b0;
    endcase
  end

  assign w_req_illegal = (REQ_LINE == 3'd7) ||
                         ((REQ_LINE <= 3'd4) && (REQ_WORD > 7'd107)) ||
                         (((REQ_LINE == 3'd5) || (REQ_LINE == 3'd6)) && (REQ_WORD > 7'd3));

  // Short lines recirculate every four word times, so only the low two bits
  // of the word time identify the word.
  assign w_is_short   = (r_line == 3'd5) || (r_line == 3'd6);
  assign w_word_match = w_is_short ? (WT[1:0] == r_word[1:0]) : (WT == r_word);

  always_comb begin
    w_state_next = r_state;
    w_line_next  = r_line;
    w_word_next  = r_word;
    w_data_next  = r_data;
    w_err_next   = r_err;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (REQ_VALID) begin
          w_line_next = REQ_LINE;
          w_word_next = REQ_WORD;
          w_data_next = '0;
          w_cnt_next  = '0;
          if (w_req_illegal) begin
            w_err_next   = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_err_next   = 1'b0;
            w_state_next = WAIT_WORD;
          end
        end
      end
      WAIT_WORD: begin
        // Bit 0 arrives in the same bit time as T0, so it is taken here.
        if (BIT_CE && T0 && w_word_match) begin
          w_data_next[0] = w_line_bit;
          w_cnt_next     = 5'd1;
          w_state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (BIT_CE) begin
          if (T0) begin
            // A new word started before this one finished: framing error.
            w_err_next   = 1'b1;
            w_data_next  = '0;
            w_state_next = HOLD;
          end else begin
            w_data_next[r_cnt] = w_line_bit;
            if (r_cnt == 5'd28) begin
              w_err_next   = 1'b0;
              w_state_next = HOLD;
            end else begin
              w_cnt_next = r_cnt + 5'd1;
            end
          end
        end
      end
      HOLD: begin
        if (RSP_READY) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_word  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_line  <= w_line_next;
      r_word  <= w_word_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign REQ_READY = (r_state == IDLE);
  assign RSP_VALID = (r_state == HOLD);
  assign RSP_DATA  = r_data;
  assign RSP_ERR   = r_err;

endmodule

// File: tb/tb_mem_line_reader.sv
// Directed bench for mem_line_reader. A small drum driver plays words onto
// all seven lines. The selected line carries the wanted data and the others
// carry its complement, so a wrong line selection shows up in RSP_DATA.
module tb_mem_line_reader;

  logic        CLOCK = 1'b0;
  logic        rst = 1'b1;
  logic        BIT_CE = 1'b0;
  logic        T0 = 1'b0;
  logic [6:0]  WT = '0;
  logic        M0 = 1'b0, M1 = 1'b0, M2 = 1'b0, M3 = 1'b0;
  logic        M19 = 1'b0, M20 = 1'b0, M23 = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [2:0]  REQ_LINE = '0;
  logic [6:0]  REQ_WORD = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [28:0] RSP_DATA;
  logic        RSP_ERR;

  int n_checks = 0;
  int n_fails  = 0;

  mem_line_reader dut (
    .CLOCK(CLOCK), .rst(rst), .BIT_CE(BIT_CE), .T0(T0), .WT(WT),
    .M0(M0), .M1(M1), .M2(M2), .M3(M3), .M19(M19), .M20(M20), .M23(M23),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_LINE(REQ_LINE), .REQ_WORD(REQ_WORD),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Plays nbits bit times of drum word wt, each BIT_CE followed by one idle
  // cycle. valid_at = index of the bit after which RSP_VALID was first seen.
  task automatic drum_word(input logic [6:0] wt, input int sel, input logic [28:0] d,
                           input int nbits, output int valid_at);
    logic [6:0] mb;
    logic       bitv;
    valid_at = -1;
    for (int b = 0; b < nbits; b++) begin
      bitv = 1'b0;
      if (b < 29) bitv = d[5'(b)];
      for (int k = 0; k < 7; k++) mb[k] = (k == sel) ? bitv : ~bitv;
      BIT_CE = 1'b1;
      T0     = (b == 0);
      WT     = wt;
      {M23, M20, M19, M3, M2, M1, M0} = mb;
      tick();
      if (RSP_VALID && valid_at < 0) valid_at = b;
      BIT_CE = 1'b0;
      T0     = 1'b0;
      tick();
    end
  endtask

  task automatic send_req(input logic [2:0] line, input logic [6:0] word);
    REQ_LINE  = line;
    REQ_WORD  = word;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic ack_rsp();
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    REQ_LINE = 3'd2; REQ_WORD = 7'd5; REQ_VALID = 1'b1; RSP_READY = 1'b1;
    repeat (3) tick();
    rst = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    n_checks++; if (REQ_READY !== 1'b1) begin n_fails++; $display("FAIL reset_req_ready got %b want 1", REQ_READY); end
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid got %b want 0", RSP_VALID); end
    n_checks++; if (RSP_ERR !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_err got %b want 0", RSP_ERR); end
    n_checks++; if (RSP_DATA !== 29'h0) begin n_fails++; $display("FAIL reset_rsp_data got %h want 0", RSP_DATA); end
    tick();
    n_checks++; if (REQ_READY !== 1'b1) begin n_fails++; $display("FAIL reset_idle_hold got %b want 1", REQ_READY); end
    $display("test_reset done");
  endtask

  task automatic test_long_read();
    int va;
    send_req(3'd2, 7'd57);
    n_checks++; if (REQ_READY !== 1'b0) begin n_fails++; $display("FAIL long_busy got %b want 0", REQ_READY); end
    drum_word(7'd55, 2, 29'h0ABCDEF, 32, va);
    n_checks++; if (va !== -1) begin n_fails++; $display("FAIL long_wt55 got %0d want -1", va); end
    drum_word(7'd56, 2, 29'h1FFFFFFF, 32, va);
    n_checks++; if (va !== -1) begin n_fails++; $display("FAIL long_wt56 got %0d want -1", va); end
    drum_word(7'd57, 2, 29'h15555555, 32, va);
    n_checks++; if (va !== 28) begin n_fails++; $display("FAIL long_latency got bit %0d want 28", va); end
    n_checks++; if (RSP_DATA !== 29'h15555555) begin n_fails++; $display("FAIL long_data got %h want 15555555", RSP_DATA); end
    n_checks++; if (RSP_ERR !== 1'b0) begin n_fails++; $display("FAIL long_err got %b want 0", RSP_ERR); end
    // Next word passes under the heads while the response is held.
    drum_word(7'd58, 2, 29'h0000000, 32, va);
    $display("test_long_read line=2 word=57 data=%h err=%b", RSP_DATA, RSP_ERR);
  endtask

  task automatic test_backpressure();
    RSP_READY = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      n_checks++; if (RSP_DATA !== 29'h15555555 || RSP_VALID !== 1'b1) begin
        n_fails++; $display("FAIL bp_hold cyc %0d got data=%h valid=%b want 15555555/1", c, RSP_DATA, RSP_VALID);
      end
      n_checks++; if (REQ_READY !== 1'b0) begin n_fails++; $display("FAIL bp_req_ready cyc %0d got %b want 0", c, REQ_READY); end
    end
    ack_rsp();
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fails++; $display("FAIL bp_release_valid got %b want 0", RSP_VALID); end
    n_checks++; if (REQ_READY !== 1'b1) begin n_fails++; $display("FAIL bp_release_ready got %b want 1", REQ_READY); end
    $display("test_backpressure done");
  endtask

  task automatic test_short_read();
    int va;
    send_req(3'd5, 7'd2);
    drum_word(7'd4, 5, 29'h1FFFFFFF, 32, va);
    n_checks++; if (va !== -1) begin n_fails++; $display("FAIL short_wt4 got %0d want -1", va); end
    drum_word(7'd5, 5, 29'h0000000, 32, va);
    n_checks++; if (va !== -1) begin n_fails++; $display("FAIL short_wt5 got %0d want -1", va); end
    drum_word(7'd6, 5, 29'h0F0F1234, 32, va);
    n_checks++; if (va !== 28) begin n_fails++; $display("FAIL short_latency got bit %0d want 28", va); end
    n_checks++; if (RSP_DATA !== 29'h0F0F1234) begin n_fails++; $display("FAIL short_data got %h want 0f0f1234", RSP_DATA); end
    n_checks++; if (RSP_ERR !== 1'b0) begin n_fails++; $display("FAIL short_err got %b want 0", RSP_ERR); end
    $display("test_short_read line=5 word=2 data=%h err=%b", RSP_DATA, RSP_ERR);
    ack_rsp();
  endtask

  task automatic test_illegal();
    send_req(3'd0, 7'd108);
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_DATA !== 29'h0) begin
      n_fails++; $display("FAIL illegal_long got v=%b e=%b d=%h want 1/1/0", RSP_VALID, RSP_ERR, RSP_DATA);
    end
    $display("test_illegal line=0 word=108 err=%b", RSP_ERR);
    ack_rsp();
    send_req(3'd6, 7'd4);
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1) begin
      n_fails++; $display("FAIL illegal_short got v=%b e=%b want 1/1", RSP_VALID, RSP_ERR);
    end
    ack_rsp();
    send_req(3'd7, 7'd0);
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_DATA !== 29'h0) begin
      n_fails++; $display("FAIL illegal_line7 got v=%b e=%b d=%h want 1/1/0", RSP_VALID, RSP_ERR, RSP_DATA);
    end
    $display("test_illegal line=7 err=%b", RSP_ERR);
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    send_req(3'd7, 7'd1);
    // Request held up while still in HOLD; it must only be taken after exit.
    REQ_LINE = 3'd7; REQ_VALID = 1'b1; RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    n_checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
      n_fails++; $display("FAIL b2b_exit got v=%b rdy=%b want 0/1", RSP_VALID, REQ_READY);
    end
    tick();
    REQ_VALID = 1'b0;
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1) begin
      n_fails++; $display("FAIL b2b_second got v=%b e=%b want 1/1", RSP_VALID, RSP_ERR);
    end
    $display("test_back_to_back second response err=%b", RSP_ERR);
    ack_rsp();
  endtask

  task automatic test_reset_mid();
    int va;
    send_req(3'd1, 7'd10);
    drum_word(7'd10, 1, 29'h1234567, 14, va);
    n_checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b0) begin
      n_fails++; $display("FAIL mid_shift got v=%b rdy=%b want 0/0", RSP_VALID, REQ_READY);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1 || RSP_DATA !== 29'h0) begin
      n_fails++; $display("FAIL mid_reset got v=%b rdy=%b d=%h want 0/1/0", RSP_VALID, REQ_READY, RSP_DATA);
    end
    send_req(3'd3, 7'd11);
    drum_word(7'd11, 3, 29'h1DEADBE, 32, va);
    n_checks++; if (va !== 28 || RSP_DATA !== 29'h1DEADBE || RSP_ERR !== 1'b0) begin
      n_fails++; $display("FAIL mid_after got bit=%0d d=%h e=%b want 28/1deadbe/0", va, RSP_DATA, RSP_ERR);
    end
    $display("test_reset_mid recovery data=%h", RSP_DATA);
    ack_rsp();
  endtask

  task automatic test_framing();
    int va;
    send_req(3'd4, 7'd20);
    drum_word(7'd20, 4, 29'h000FFFF, 10, va);
    n_checks++; if (va !== -1) begin n_fails++; $display("FAIL frame_early got %0d want -1", va); end
    drum_word(7'd21, 4, 29'h000FFFF, 1, va);
    n_checks++; if (va !== 0 || RSP_ERR !== 1'b1) begin
      n_fails++; $display("FAIL frame_err got bit=%0d e=%b want 0/1", va, RSP_ERR);
    end
    $display("test_framing err=%b", RSP_ERR);
    ack_rsp();
    n_checks++; if (REQ_READY !== 1'b1) begin n_fails++; $display("FAIL frame_release got %b want 1", REQ_READY); end
  endtask

  initial begin
    #1;
    test_reset();
    test_long_read();
    test_backpressure();
    test_short_read();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_framing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
